// File: rtl/keypad_pkg.sv
// Shared constants and state encoding for the matrix-keypad scanner.
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int CODE_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD
  } scan_state_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-code handshake between the scanner (master) and its consumer (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ack;
  logic              key_held;
  logic              overflow;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overflow,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overflow,
    output key_ack
  );

endinterface

// File: rtl/keypad_tick.sv
// Dwell counter: free-running 0..DWELL-1 with a one-cycle strobe on terminal count.
module keypad_tick #(
  parameter int DWELL = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(DWELL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: column strobe, debounce FSM and one-entry valid/ack code register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ             = 100_000_000,
  parameter int SCAN_HZ            = 1000,
  parameter int DEBOUNCE_SCANS     = 4,
  parameter int REPEAT_DELAY_SCANS = 500,
  parameter int REPEAT_RATE_SCANS  = 100
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  keypad_scanner_if.master  key
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  logic [ROWS-1:0]  row_meta;
  logic [ROWS-1:0]  row_sync;
  logic             tick;
  scan_state_t      state;
  scan_state_t      state_next;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] lat_row;
  logic [ROW_W-1:0] lat_row_next;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_cnt_next;
  logic             any_low;
  logic [ROW_W-1:0] low_row;
  logic             fire;
  logic [CODE_W-1:0] new_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                           REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_next;
  logic             rep_phase;
  logic             rep_phase_next;
  logic [REP_W-1:0] rep_last;

  assign rep_last = rep_phase ? REP_W'(REPEAT_RATE_SCANS - 1)
                              : REP_W'(REPEAT_DELAY_SCANS - 1);
`endif

  keypad_tick #(
    .DWELL (DWELL)
  ) u_tick (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Lowest-indexed pressed row wins, so scan from the top down and let later hits override.
  always_comb begin
    any_low = 1'b0;
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_sync[r]) begin
        any_low = 1'b1;
        low_row = ROW_W'(r);
      end
    end
  end

  assign col_n        = ~(COLS'(1) << col);
  assign new_code     = {lat_row, col};
  assign key.key_held = (state == HELD);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col       <= '0;
      lat_row   <= '0;
      db_cnt    <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      col       <= col_next;
      lat_row   <= lat_row_next;
      db_cnt    <= db_cnt_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_cnt_next;
      rep_phase <= rep_phase_next;
`endif
    end
  end

  // The column stays frozen on the detected key through CONFIRM and HELD; db_cnt is reused as the release count in HELD.
  always_comb begin
    state_next   = state;
    col_next     = col;
    lat_row_next = lat_row;
    db_cnt_next  = db_cnt;
    fire         = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next   = rep_cnt;
    rep_phase_next = rep_phase;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            lat_row_next = low_row;
            db_cnt_next  = DB_W'(1);
            state_next   = CONFIRM;
          end else begin
            col_next = col + 1'b1;
          end
        end
        CONFIRM: begin
          if (any_low && (low_row == lat_row)) begin
            if (db_cnt == DB_W'(DEBOUNCE_SCANS - 1)) begin
              fire        = 1'b1;
              db_cnt_next = '0;
              state_next  = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_next   = '0;
              rep_phase_next = 1'b0;
`endif
            end else begin
              db_cnt_next = db_cnt + 1'b1;
            end
          end else begin
            db_cnt_next = '0;
            col_next    = col + 1'b1;
            state_next  = SCAN;
          end
        end
        HELD: begin
          if (row_sync[lat_row]) begin
            if (db_cnt == DB_W'(DEBOUNCE_SCANS - 1)) begin
              db_cnt_next = '0;
              col_next    = col + 1'b1;
              state_next  = SCAN;
            end else begin
              db_cnt_next = db_cnt + 1'b1;
            end
          end else begin
            db_cnt_next = '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt == rep_last) begin
              fire           = 1'b1;
              rep_cnt_next   = '0;
              rep_phase_next = 1'b1;
            end else begin
              rep_cnt_next = rep_cnt + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_next = SCAN;
        end
      endcase
    end
  end

  // A same-cycle ack frees the register for an incoming event; the later load overrides the ack clear of key_valid.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      key.key_code  <= '0;
      key.key_valid <= 1'b0;
      key.overflow  <= 1'b0;
    end else begin
      if (key.key_ack && key.key_valid) begin
        key.key_valid <= 1'b0;
        key.overflow  <= 1'b0;
      end
      if (fire) begin
        if (!key.key_valid || key.key_ack) begin
          key.key_code  <= new_code;
          key.key_valid <= 1'b1;
        end else begin
          key.overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner; a keypad model shorts row r to column c for each pressed key.
module tb_keypad_scanner;

  logic        clk_100mhz = 1'b0;
  logic        rst_n      = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] key_down   = '0;
  int          edge_n;
  int          checks     = 0;
  int          passes     = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .CLK_HZ             (1000),
    .SCAN_HZ            (100),
    .DEBOUNCE_SCANS     (4),
    .REPEAT_DELAY_SCANS (5),
    .REPEAT_RATE_SCANS  (2)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .key        (kp)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Edge index counted from reset release: edge 1 is the first rising edge after rst_n goes high.
  always @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(key_down[r*4 +: 4] & ~col_n);
    end
  end

  task automatic wait_edge(input int e);
    while (edge_n < e) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask

  task automatic do_reset;
    kp.key_ack = 1'b0;
    key_down   = '0;
    exp_q.delete();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic pop_expected;
    checks++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got event with code %h, required a queued expectation", kp.key_code);
      exp_code = 4'hx;
    end else begin
      passes++;
      exp_code = exp_q.pop_front();
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (col_n !== 4'b1110) $display("[TB] FAIL reset_col_n: got %b required 1110", col_n); else passes++;
    checks++; if (kp.key_code !== 4'h0) $display("[TB] FAIL reset_code: got %h required 0", kp.key_code); else passes++;
    checks++; if (kp.key_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b required 0", kp.key_valid); else passes++;
    checks++; if (kp.key_held !== 1'b0) $display("[TB] FAIL reset_held: got %b required 0", kp.key_held); else passes++;
    checks++; if (kp.overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b required 0", kp.overflow); else passes++;
    wait_edge(9);
    checks++; if (col_n !== 4'b1110) $display("[TB] FAIL reset_col_hold: got %b required 1110", col_n); else passes++;
    wait_edge(10);
    checks++; if (col_n !== 4'b1101) $display("[TB] FAIL reset_col_step: got %b required 1101", col_n); else passes++;
    wait_edge(20);
    checks++; if (col_n !== 4'b1011) $display("[TB] FAIL reset_col_step2: got %b required 1011", col_n); else passes++;
  endtask

  task automatic test_press;
    do_reset();
    key_down[9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_edge(49);
    checks++; if (kp.key_valid !== 1'b0) $display("[TB] FAIL press_early_valid: got %b required 0", kp.key_valid); else passes++;
    wait_edge(50);
    checks++; if (kp.key_valid !== 1'b1) $display("[TB] FAIL press_valid: got %b required 1", kp.key_valid); else passes++;
    pop_expected();
    checks++; if (kp.key_code !== exp_code) $display("[TB] FAIL press_code: got %h required %h", kp.key_code, exp_code); else passes++;
    checks++; if (kp.key_held !== 1'b1) $display("[TB] FAIL press_held: got %b required 1", kp.key_held); else passes++;
    checks++; if (col_n !== 4'b1101) $display("[TB] FAIL press_col_frozen: got %b required 1101", col_n); else passes++;
    kp.key_ack = 1'b1;
    wait_edge(51);
    kp.key_ack  = 1'b0;
    key_down[9] = 1'b0;
    checks++; if (kp.key_valid !== 1'b0) $display("[TB] FAIL press_ack: got %b required 0", kp.key_valid); else passes++;
    wait_edge(89);
    checks++; if (kp.key_held !== 1'b1) $display("[TB] FAIL release_early: got %b required 1", kp.key_held); else passes++;
    wait_edge(90);
    checks++; if (kp.key_held !== 1'b0) $display("[TB] FAIL release_held: got %b required 0", kp.key_held); else passes++;
    checks++; if (col_n !== 4'b1011) $display("[TB] FAIL release_col: got %b required 1011", col_n); else passes++;
  endtask

  task automatic test_bounce;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      key_down[0] = (i % 2 == 0);
      for (int e = 15 * i + 1; e <= 15 * (i + 1); e++) begin
        wait_edge(e);
        checks++;
        if (kp.key_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL bounce_valid@%0d: got %b required 0", e, kp.key_valid);
        end else passes++;
      end
    end
    key_down[0] = 1'b0;
    wait_edge(125);
    checks++; if (col_n !== 4'b1011) $display("[TB] FAIL bounce_col_a: got %b required 1011", col_n); else passes++;
    wait_edge(135);
    checks++; if (col_n !== 4'b0111) $display("[TB] FAIL bounce_col_b: got %b required 0111", col_n); else passes++;
    wait_edge(145);
    checks++; if (col_n !== 4'b1110) $display("[TB] FAIL bounce_col_c: got %b required 1110", col_n); else passes++;
    if (bad != 0) $display("[TB] bounce saw %0d bad cycles", bad);
  endtask

  task automatic test_overflow;
    do_reset();
    key_down[0] = 1'b1;
    exp_q.push_back(4'h0);
    wait_edge(40);
    checks++; if (kp.key_valid !== 1'b1) $display("[TB] FAIL ovf_first_valid: got %b required 1", kp.key_valid); else passes++;
    pop_expected();
    checks++; if (kp.key_code !== exp_code) $display("[TB] FAIL ovf_first_code: got %h required %h", kp.key_code, exp_code); else passes++;
    wait_edge(41);
    key_down[0]  = 1'b0;
    key_down[15] = 1'b1;
    wait_edge(139);
    checks++; if (kp.overflow !== 1'b0) $display("[TB] FAIL ovf_early: got %b required 0", kp.overflow); else passes++;
    wait_edge(140);
    checks++; if (kp.overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %b required 1", kp.overflow); else passes++;
    checks++; if (kp.key_code !== 4'h0) $display("[TB] FAIL ovf_code_kept: got %h required 0", kp.key_code); else passes++;
    checks++; if (kp.key_held !== 1'b1) $display("[TB] FAIL ovf_held: got %b required 1", kp.key_held); else passes++;
    kp.key_ack = 1'b1;
    wait_edge(141);
    kp.key_ack   = 1'b0;
    key_down[15] = 1'b0;
    checks++; if (kp.key_valid !== 1'b0) $display("[TB] FAIL ovf_ack_valid: got %b required 0", kp.key_valid); else passes++;
    checks++; if (kp.overflow !== 1'b0) $display("[TB] FAIL ovf_ack_clear: got %b required 0", kp.overflow); else passes++;
  endtask

  task automatic test_ack_collide;
    do_reset();
    key_down[0] = 1'b1;
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h6);
    wait_edge(40);
    pop_expected();
    checks++; if (kp.key_code !== exp_code) $display("[TB] FAIL coll_first_code: got %h required %h", kp.key_code, exp_code); else passes++;
    wait_edge(41);
    key_down[0] = 1'b0;
    key_down[6] = 1'b1;
    wait_edge(129);
    checks++; if (kp.key_valid !== 1'b1) $display("[TB] FAIL coll_pending: got %b required 1", kp.key_valid); else passes++;
    kp.key_ack = 1'b1;
    wait_edge(130);
    kp.key_ack = 1'b0;
    checks++; if (kp.key_valid !== 1'b1) $display("[TB] FAIL coll_valid: got %b required 1", kp.key_valid); else passes++;
    pop_expected();
    checks++; if (kp.key_code !== exp_code) $display("[TB] FAIL coll_code: got %h required %h", kp.key_code, exp_code); else passes++;
    checks++; if (kp.overflow !== 1'b0) $display("[TB] FAIL coll_overflow: got %b required 0", kp.overflow); else passes++;
    wait_edge(131);
    key_down[6] = 1'b0;
    checks++; if (kp.key_valid !== 1'b1) $display("[TB] FAIL coll_valid_hold: got %b required 1", kp.key_valid); else passes++;
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat;
    int ev_edge[4] = '{50, 100, 120, 140};
    do_reset();
    key_down[5] = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'h5);
    for (int i = 0; i < 4; i++) begin
      wait_edge(ev_edge[i] - 1);
      checks++; if (kp.key_valid !== 1'b0) $display("[TB] FAIL rep_early%0d: got %b required 0", i, kp.key_valid); else passes++;
      wait_edge(ev_edge[i]);
      checks++; if (kp.key_valid !== 1'b1) $display("[TB] FAIL rep_valid%0d: got %b required 1", i, kp.key_valid); else passes++;
      pop_expected();
      checks++; if (kp.key_code !== exp_code) $display("[TB] FAIL rep_code%0d: got %h required %h", i, kp.key_code, exp_code); else passes++;
      kp.key_ack = 1'b1;
      wait_edge(ev_edge[i] + 1);
      kp.key_ack = 1'b0;
    end
    wait_edge(145);
    rst_n = 1'b0;
    #1;
    checks++; if (col_n !== 4'b1110) $display("[TB] FAIL rep_rst_col: got %b required 1110", col_n); else passes++;
    checks++; if (kp.key_held !== 1'b0) $display("[TB] FAIL rep_rst_held: got %b required 0", kp.key_held); else passes++;
    checks++; if (kp.key_valid !== 1'b0) $display("[TB] FAIL rep_rst_valid: got %b required 0", kp.key_valid); else passes++;
    checks++; if (kp.key_code !== 4'h0) $display("[TB] FAIL rep_rst_code: got %h required 0", kp.key_code); else passes++;
    checks++; if (kp.overflow !== 1'b0) $display("[TB] FAIL rep_rst_overflow: got %b required 0", kp.overflow); else passes++;
    key_down = '0;
    @(negedge clk_100mhz);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    kp.key_ack = 1'b0;
    test_reset();
    test_press();
    test_bounce();
    test_overflow();
    test_ack_collide();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad reader for the labkit's PMOD headers. It is the input-side counterpart of the multiplexed seven-segment writer: that block strobes active-low `dig` lines, and this block strobes active-low column lines and reads the active-low row lines back. Each detected press is debounced, encoded to a 4-bit key code and held in a one-entry valid/ack register. Game and score logic consume the codes in place of raw button wires.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency.
- `SCAN_HZ`, 1000: column dwell rate, giving `DWELL = CLK_HZ/SCAN_HZ` cycles per column.
- `DEBOUNCE_SCANS`, 4: consecutive matching samples required to confirm a press or a release.
- `REPEAT_DELAY_SCANS`, 500: dwell ticks from the first event to the first repeat (only with `KEYPAD_REPEAT_EN`).
- `REPEAT_RATE_SCANS`, 100: dwell ticks between subsequent repeats (only with `KEYPAD_REPEAT_EN`).

Ports:
- `clk_100mhz` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `row_n` input 4: keypad rows, pulled up, low = pressed.
- `col_n` output 4: column strobes, active-low, exactly one low at a time.
- `key_code` output 4: `row*4 + col` of the last accepted key.
- `key_valid` output 1: the code is pending; stays high until acknowledged.
- `key_ack` input 1: consumer accepts the pending code.
- `key_held` output 1: a confirmed key is currently down.
- `overflow` output 1: sticky; an event was dropped because `key_valid` was still high.

## Operation
- `row_n` passes through a 2-flop synchronizer.
- A dwell counter runs 0..DWELL-1. Its terminal count is the "tick"; the synchronized rows are sampled only on a tick.
- If several rows are low, the lowest-indexed row wins.
- State machine:
  - SCAN: on each tick, if no row is low, the column rotates 0→1→2→3→0. If a row is low, the block latches (row, col), sets match count = 1, freezes the column and goes to CONFIRM.
  - CONFIRM: on each tick, the same row low increments the count. When the count reaches `DEBOUNCE_SCANS`, the block emits an event and goes to HELD. Any differing sample returns to SCAN and advances the column.
  - HELD: `key_held` = 1 and the column stays frozen. `DEBOUNCE_SCANS` consecutive ticks with the row high return to SCAN and advance the column. Any low sample resets the release count.
- Event emission into the output register:
  - `key_valid` = 0, or `key_ack` = 1 in the same cycle: load `key_code`, set `key_valid`.
  - Otherwise: drop the new code and set `overflow`.
- Acknowledge: `key_ack` while `key_valid` = 1 clears `key_valid` and `overflow`, unless an event loads in the same cycle, in which case `key_valid` stays 1. `key_ack` while `key_valid` = 0 is ignored.
- Reset values: `col_n` = 4'b1110, `key_code` = 0, `key_valid` = 0, `key_held` = 0, `overflow` = 0. All counters are 0 and the state is SCAN.
- An asserted `rst_n` in any state returns immediately to the reset values. A pending code is lost.

## Timing
- A row change becomes visible to sampling 2 cycles later, because of the synchronizer.
- `key_valid` and `key_code` update on the clock edge after the confirming tick.
- Minimum press-to-valid latency is `DEBOUNCE_SCANS` ticks after the detecting tick's column, plus 1 cycle.
- `col_n` changes only on the edge following a tick and is stable for a full DWELL.
- `key_held` rises together with the event and falls on the edge after the last release tick.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a tick counter emits a repeat event `REPEAT_DELAY_SCANS` ticks after the first event, then every `REPEAT_RATE_SCANS` ticks.
  - Repeat events follow the same load/overflow rules as first events.
- `KEYPAD_REPEAT_EN` undefined: there is exactly one event per press, and the repeat counter and parameters are unused.

## Structure
- Package `keypad_pkg` holds:
  - the state enum (SCAN, CONFIRM, HELD);
  - the ROWS = 4 / COLS = 4 constants;
  - the key-code width constant.
- Sub-module `keypad_tick`: the dwell counter producing the one-cycle tick strobe.
- The synchronizer, FSM and output register live in `keypad_scanner`.

## Test plan
All scenarios use `CLK_HZ`=1000, `SCAN_HZ`=100 (DWELL = 10) and `DEBOUNCE_SCANS`=4.
- Reset: after deasserting `rst_n`, `col_n` = 1110, all outputs are 0, and `col_n` steps to 1101 after 10 cycles.
- Press row 2 / col 1 steadily: `key_code` = 4'h9, `key_valid` = 1 one cycle after the 4th matching tick, `key_held` = 1. Pulsing `key_ack` → `key_valid` = 0.
- Bounce: row 0 toggles low/high every 15 cycles during CONFIRM → `key_valid` never rises and the scan resumes rotating.
- Two presses without ack (key 0 then key 15): `key_code` stays 4'h0 and `overflow` = 1. A subsequent ack clears both.
- Ack coinciding with a new event: `key_valid` stays 1, `key_code` takes the new value, `overflow` stays 0.
- With `KEYPAD_REPEAT_EN`, `REPEAT_DELAY_SCANS`=5 and `REPEAT_RATE_SCANS`=2, hold key 4'h5 with an ack after each event: repeats arrive 5 ticks after the first event, then every 2 ticks. Asserting `rst_n` mid-HELD restores all reset values.
